// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle execute stage: op codes, flag-update
// codes, FSM states and the iterative-engine operating modes.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_ADC   = 4'h1,
        OP_SUB   = 4'h2,
        OP_SBB   = 4'h3,
        OP_AND   = 4'h4,
        OP_OR    = 4'h5,
        OP_XOR   = 4'h6,
        OP_NOT   = 4'h7,
        OP_SHL   = 4'h8,
        OP_SHR   = 4'h9,
        OP_SAR   = 4'hA,
        OP_MUL   = 4'hB,
        OP_CLC   = 4'hC,
        OP_STC   = 4'hD,
        OP_RSV_E = 4'hE,
        OP_RSV_F = 4'hF
    } alu_op_e;

    // Flag-register update codes carried on sst.
    localparam logic [1:0] SST_LOAD = 2'b00;
    localparam logic [1:0] SST_CLC  = 2'b01;
    localparam logic [1:0] SST_STC  = 2'b10;
    localparam logic [1:0] SST_HOLD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ITER_SHL = 2'd0,
        ITER_SHR = 2'd1,
        ITER_SAR = 2'd2,
        ITER_MUL = 2'd3
    } iter_mode_e;

endpackage

// File: rtl/alu_iter_engine.sv
// Iterative datapath: one shift bit or one shift-add multiply step per cycle.
// Exposes the post-step value so the caller can register it on the final step.
module alu_iter_engine
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  iter_mode_e       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             finish,
    output logic [WIDTH-1:0] step_result,
    output logic             step_carry,
    output logic             step_ovf
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    iter_mode_e         mode_q;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mcand;
    logic [CW-1:0]      count;
    logic [WIDTH:0]     mul_sum;
    logic [CW-1:0]      count_init;

    // Multiply keeps the multiplier in the low half and accumulates in the
    // high half; the whole pair shifts right each step, so after WIDTH steps
    // acc holds the full 2*WIDTH product.
    always_comb begin
        if (mode == ITER_MUL) begin
            count_init = CW'(WIDTH);
        end else begin
            count_init = {1'b0, b[SHW-1:0]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= ITER_SHL;
            acc    <= '0;
            mcand  <= '0;
            count  <= '0;
        end else if (load) begin
            mode_q <= mode;
            mcand  <= a;
            count  <= count_init;
            if (mode == ITER_MUL) begin
                acc <= {{WIDTH{1'b0}}, b};
            end else begin
                acc <= {{WIDTH{1'b0}}, a};
            end
        end else if (step) begin
            acc   <= acc_nxt;
            count <= count - CW'(1);
        end
    end

    always_comb begin
        mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]}
                   + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        acc_nxt    = acc;
        step_carry = 1'b0;
        step_ovf   = 1'b0;
        case (mode_q)
            ITER_SHL: begin
                acc_nxt    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0};
                step_carry = acc[WIDTH-1];
            end
            ITER_SHR: begin
                acc_nxt    = {acc[2*WIDTH-1:WIDTH], 1'b0, acc[WIDTH-1:1]};
                step_carry = acc[0];
            end
            ITER_SAR: begin
                acc_nxt    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1], acc[WIDTH-1:1]};
                step_carry = acc[0];
            end
            ITER_MUL: begin
                acc_nxt    = {mul_sum, acc[WIDTH-1:1]};
                step_carry = |acc_nxt[2*WIDTH-1:WIDTH];
                step_ovf   = |acc_nxt[2*WIDTH-1:WIDTH];
            end
            default: begin
                acc_nxt = acc;
            end
        endcase
    end

    assign step_result = acc_nxt[WIDTH-1:0];
    assign finish      = (count == CW'(1));

endmodule

// File: rtl/alu_seq_exec.sv
// Multi-cycle execute stage: single-cycle ALU ops plus iterative shift/multiply,
// presenting result, flag candidates and the flag-update code once per op.
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c,
    output logic             z,
    output logic             v,
    output logic             s,
    output logic [1:0]       sst
);

    localparam int SHW = $clog2(WIDTH);

    // Handshake: an op is taken on any rising edge where start=1 and ready=1;
    // ready is low only while an iterative op runs. done pulses for one cycle
    // per accepted op, and sst is SST_HOLD in every cycle where done=0.

    state_e           state;
    state_e           nxt_state;
    alu_op_e          op_e;
    logic             carry_in;
    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic [SHW-1:0]   shamt;

    logic [WIDTH-1:0] sc_result;
    logic             sc_c;
    logic             sc_v;
    logic [1:0]       sc_sst;
    logic             sc_iter;
    logic             sc_rsv;
    iter_mode_e       eng_mode;

    logic             eng_load;
    logic             eng_step;
    logic             eng_finish;
    logic [WIDTH-1:0] eng_result;
    logic             eng_carry;
    logic             eng_ovf;

    logic             cap_en;
    logic [WIDTH-1:0] cap_result;
    logic             cap_c;
    logic             cap_v;
    logic             cap_z;
    logic             cap_s;
    logic [1:0]       cap_sst;
    logic             cap_rsv;

    logic             done_q;
    logic [1:0]       sst_q;
    logic [WIDTH-1:0] result_q;
    logic             c_q;
    logic             z_q;
    logic             v_q;
    logic             s_q;

    assign op_e     = alu_op_e'(op);
    assign shamt    = b[SHW-1:0];
    assign carry_in = (op_e == OP_ADC || op_e == OP_SBB) ? cin : 1'b0;
    assign add_ext  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
    assign sub_ext  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, carry_in};

    // Single-cycle decode; shifts with a zero count also finish here.
    always_comb begin
        sc_result = '0;
        sc_c      = 1'b0;
        sc_v      = 1'b0;
        sc_sst    = SST_LOAD;
        sc_iter   = 1'b0;
        sc_rsv    = 1'b0;
        eng_mode  = ITER_MUL;
        case (op_e)
            OP_ADD, OP_ADC: begin
                sc_result = add_ext[WIDTH-1:0];
                sc_c      = add_ext[WIDTH];
                sc_v      = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_SBB: begin
                sc_result = sub_ext[WIDTH-1:0];
                sc_c      = sub_ext[WIDTH];
                sc_v      = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: begin sc_result = a & b; sc_c = cin; end
            OP_OR:  begin sc_result = a | b; sc_c = cin; end
            OP_XOR: begin sc_result = a ^ b; sc_c = cin; end
            OP_NOT: begin sc_result = ~a;    sc_c = cin; end
            OP_SHL, OP_SHR, OP_SAR: begin
                if (op_e == OP_SHL) eng_mode = ITER_SHL;
                else if (op_e == OP_SHR) eng_mode = ITER_SHR;
                else eng_mode = ITER_SAR;
                if (shamt == '0) begin
                    sc_result = a;
                    sc_c      = cin;
                end else begin
                    sc_iter = 1'b1;
                end
            end
            OP_MUL: begin
                eng_mode = ITER_MUL;
                sc_iter  = 1'b1;
            end
            OP_CLC: begin sc_result = a; sc_sst = SST_CLC; end
            OP_STC: begin sc_result = a; sc_sst = SST_STC; sc_c = 1'b1; end
            default: begin
                sc_sst = SST_HOLD;
                sc_rsv = 1'b1;
            end
        endcase
    end

    always_comb begin
        nxt_state  = state;
        eng_load   = 1'b0;
        cap_en     = 1'b0;
        cap_result = sc_result;
        cap_c      = sc_c;
        cap_v      = sc_v;
        cap_sst    = sc_sst;
        cap_rsv    = sc_rsv;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (sc_iter) begin
                        nxt_state = ST_ITER;
                        eng_load  = 1'b1;
                    end else begin
                        nxt_state = ST_DONE;
                        cap_en    = 1'b1;
                    end
                end else begin
                    nxt_state = ST_IDLE;
                end
            end
            ST_ITER: begin
                if (eng_finish) begin
                    nxt_state  = ST_DONE;
                    cap_en     = 1'b1;
                    cap_result = eng_result;
                    cap_c      = eng_carry;
                    cap_v      = eng_ovf;
                    cap_sst    = SST_LOAD;
                    cap_rsv    = 1'b0;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
        cap_z = (cap_result == '0) && !cap_rsv;
        cap_s = cap_result[WIDTH-1];
    end

    assign eng_step = (state == ST_ITER);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            done_q   <= 1'b0;
            sst_q    <= SST_HOLD;
            result_q <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            v_q      <= 1'b0;
            s_q      <= 1'b0;
        end else begin
            state  <= nxt_state;
            done_q <= cap_en;
            if (cap_en) begin
                result_q <= cap_result;
                c_q      <= cap_c;
                z_q      <= cap_z;
                v_q      <= cap_v;
                s_q      <= cap_s;
                sst_q    <= cap_sst;
            end else begin
                sst_q <= SST_HOLD;
            end
        end
    end

    alu_iter_engine #(.WIDTH(WIDTH)) u_iter (
        .clk         (clk),
        .reset       (reset),
        .load        (eng_load),
        .step        (eng_step),
        .mode        (eng_mode),
        .a           (a),
        .b           (b),
        .finish      (eng_finish),
        .step_result (eng_result),
        .step_carry  (eng_carry),
        .step_ovf    (eng_ovf)
    );

    assign ready  = (state != ST_ITER);
    assign done   = done_q;
    assign sst    = sst_q;
    assign result = result_q;
    assign c      = c_q;
    assign z      = z_q;
    assign v      = v_q;
    assign s      = s_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed bench for alu_seq_exec: hand-computed vectors, latency, back-to-back
// flag codes, ignored starts during iteration and reset abort.
module tb_alu_seq_exec;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         ready;
    logic         done;
    logic [W-1:0] result;
    logic         c, z, v, s;
    logic [1:0]   sst;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    alu_seq_exec #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .ready  (ready),
        .done   (done),
        .result (result),
        .c      (c),
        .z      (z),
        .v      (v),
        .s      (s),
        .sst    (sst)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one op, wait for done (bounded), compare outputs and latency.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] ia,
                          input logic [W-1:0] ib, input logic ic, input logic [W-1:0] e_res,
                          input logic e_c, input logic e_v, input logic e_z, input logic e_s,
                          input logic [1:0] e_sst, input int e_lat);
        int lat;
        logic [W-1:0] exp_res;
        lat = 0;
        exp_q.push_back(e_res);
        @(negedge clk);
        start = 1'b1; op = o; a = ia; b = ib; cin = ic;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
        end while (!done && lat < 40);
        exp_res = exp_q.pop_front();
        check({tag, " latency"}, lat, e_lat);
        check({tag, " result"}, result, exp_res);
        check({tag, " c"}, c, e_c);
        check({tag, " v"}, v, e_v);
        check({tag, " z"}, z, e_z);
        check({tag, " s"}, s, e_s);
        check({tag, " sst"}, sst, e_sst);
        @(negedge clk);
        check({tag, " done drop"}, done, 1'b0);
        check({tag, " sst idle"}, sst, 2'b11);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst ready", ready, 1'b1);
        check("rst done", done, 1'b0);
        check("rst result", result, 16'h0000);
        check("rst flags", {c, z, v, s}, 4'b0000);
        check("rst sst", sst, 2'b11);
        reset = 1'b1;

        //      tag    op    a        b        cin   result   c     v     z     s     sst    lat
        run_op("add",  4'h0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1);
        run_op("sbb",  4'h3, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1);
        run_op("sub",  4'h2, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1);
        run_op("subv", 4'h2, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1);
        run_op("adc",  4'h1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1);
        run_op("xor",  4'h6, 16'hF0F0, 16'hFF00, 1'b1, 16'h0FF0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1);
        run_op("not",  4'h7, 16'h00FF, 16'h0000, 1'b0, 16'hFF00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1);
        run_op("shl1", 4'h8, 16'h8001, 16'h0001, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2);
        run_op("sar15",4'hA, 16'h8000, 16'h000F, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 16);
        run_op("shl0", 4'h8, 16'h1234, 16'h0000, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1);
        run_op("shr1", 4'h9, 16'h00F1, 16'h0001, 1'b0, 16'h0078, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2);
        run_op("mul",  4'hB, 16'h0003, 16'h0005, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 17);
        run_op("rsvE", 4'hE, 16'h1111, 16'h2222, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1);

        // MUL overflow with start pulses during iteration that must be ignored.
        @(negedge clk);
        start = 1'b1; op = 4'hB; a = 16'h0100; b = 16'h0100; cin = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("mul ready low", ready, 1'b0);
            check("mul no done", done, 1'b0);
            start = k[0]; op = 4'h0; a = 16'h0001; b = 16'h0001;
        end
        @(negedge clk);
        start = 1'b0;
        check("mul16 done", done, 1'b1);
        check("mul16 result", result, 16'h0000);
        check("mul16 cvz", {c, v, z}, 3'b111);
        @(negedge clk);
        check("mul16 ignored start", done, 1'b0);

        // CLC then STC back-to-back.
        @(negedge clk);
        start = 1'b1; op = 4'hC; a = 16'h00AA; b = '0;
        @(negedge clk);
        check("clc done", done, 1'b1);
        check("clc sst", sst, 2'b01);
        check("clc result", result, 16'h00AA);
        op = 4'hD; a = 16'h0055;
        @(negedge clk);
        start = 1'b0;
        check("stc done", done, 1'b1);
        check("stc sst", sst, 2'b10);
        check("stc result", result, 16'h0055);
        @(negedge clk);
        check("b2b done drop", done, 1'b0);

        // Reset in the middle of a multiply.
        @(negedge clk);
        start = 1'b1; op = 4'hB; a = 16'h0003; b = 16'h0007;
        repeat (5) @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        #1;
        check("abort result", result, 16'h0000);
        check("abort done", done, 1'b0);
        check("abort sst", sst, 2'b11);
        check("abort ready", ready, 1'b1);
        check("abort flags", {c, z, v, s}, 4'b0000);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || sst != 2'b11) check("abort late done", {done, sst}, 3'b011);
        end
        check("abort quiet sst", sst, 2'b11);
        run_op("post", 4'h0, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
